// File: rtl/msrv32_integer_file.sv
// msrv32_integer_file
// 32 x WIDTH general-purpose register file for the msrv32 core.
// Two combinational read ports and one synchronous write port. Register x0
// is hard-wired to zero. A write in flight is forwarded to any read port
// that addresses the same register, so a consumer in the same cycle sees
// the new value without waiting for the edge.
module msrv32_integer_file #(
    parameter int WIDTH = 32
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic [4:0]       rs_1_addr_in,
    input  logic [4:0]       rs_2_addr_in,
    input  logic [4:0]       rd_addr_in,
    input  logic             wr_en_in,
    input  logic [WIDTH-1:0] rd_in,
    output logic [WIDTH-1:0] rs_1_out,
    output logic [WIDTH-1:0] rs_2_out
);

    logic [WIDTH-1:0] regFile_q [32];
    logic [WIDTH-1:0] regFile_d [32];
    logic             writeValid;

    // A write to x0 is silently dropped, so it neither stores nor forwards
    assign writeValid = wr_en_in && (rd_addr_in != 5'd0);

    // Next storage image: only the addressed register takes rd_in
    always_comb begin
        regFile_d = regFile_q;
        if (writeValid) begin
            regFile_d[rd_addr_in] = rd_in;
        end
    end

    // Storage update; reset clears every register and overrides a pending write
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            for (int i = 0; i < 32; i++) begin
                regFile_q[i] <= '0;
            end
        end else begin
            regFile_q <= regFile_d;
        end
    end

    // Read port 1: x0 forced to zero, otherwise forward a matching write, else storage
    always_comb begin
        rs_1_out = regFile_q[rs_1_addr_in];
        if (rs_1_addr_in == 5'd0) begin
            rs_1_out = '0;
        end else if (writeValid && (rd_addr_in == rs_1_addr_in)) begin
            rs_1_out = rd_in;
        end
    end

    // Read port 2: same selection as port 1, evaluated independently
    always_comb begin
        rs_2_out = regFile_q[rs_2_addr_in];
        if (rs_2_addr_in == 5'd0) begin
            rs_2_out = '0;
        end else if (writeValid && (rd_addr_in == rs_2_addr_in)) begin
            rs_2_out = rd_in;
        end
    end

endmodule

// File: tb/tb_msrv32_integer_file.sv
// tb_msrv32_integer_file
// Self-checking bench for the msrv32 register file. Directed scenarios cover
// reset, x0 behaviour, forwarding and back-to-back writes; a randomized pass
// compares both read ports against a simple array model of the register file.
module tb_msrv32_integer_file;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic [4:0]  rdAddr;
    logic        wrEn;
    logic [31:0] rdData;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;

    logic [31:0] refRegs [32];
    int          checks   = 0;
    int          failures = 0;

    msrv32_integer_file #(.WIDTH(32)) dut (
        .ms_riscv32_mp_clk_in (clock),
        .ms_riscv32_mp_rst_in (reset),
        .rs_1_addr_in         (rs1Addr),
        .rs_2_addr_in         (rs2Addr),
        .rd_addr_in           (rdAddr),
        .wr_en_in             (wrEn),
        .rd_in                (rdData),
        .rs_1_out             (rs1Data),
        .rs_2_out             (rs2Data)
    );

    // Free-running clock, 10 time-unit period
    always #5 clock = ~clock;

    task automatic driveInputs(input logic rst, input logic we, input logic [4:0] rd,
                               input logic [31:0] data, input logic [4:0] a1,
                               input logic [4:0] a2);
        reset   = rst;
        wrEn    = we;
        rdAddr  = rd;
        rdData  = data;
        rs1Addr = a1;
        rs2Addr = a2;
    endtask

    // Advance one rising edge and apply the architectural effect to the model
    task automatic stepClock();
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 32; i++) refRegs[i] = 32'h0;
        end else if (wrEn && rdAddr != 5'd0) begin
            refRegs[rdAddr] = rdData;
        end
        #1;
    endtask

    // Architectural value a read port must show given the present inputs
    function automatic logic [31:0] expectRead(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wrEn && rdAddr != 5'd0 && rdAddr == a) return rdData;
        return refRegs[a];
    endfunction

    task automatic test_reset();
        driveInputs(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        stepClock();
        driveInputs(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            rs1Addr = 5'(i);
            rs2Addr = 5'(31 - i);
            #1;
            checks++;
            if (rs1Data !== 32'h0) begin
                failures++;
                $display("[TB] FAIL reset_sweep_rs1 addr=%0d got=%h expected=%h", i, rs1Data, 32'h0);
            end
            checks++;
            if (rs2Data !== 32'h0) begin
                failures++;
                $display("[TB] FAIL reset_sweep_rs2 addr=%0d got=%h expected=%h", 31 - i, rs2Data, 32'h0);
            end
        end
    endtask

    task automatic test_basic_write();
        driveInputs(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        stepClock();
        driveInputs(1'b0, 1'b1, 5'd6, 32'h12345678, 5'd0, 5'd0);
        stepClock();
        driveInputs(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
        #1;
        checks++;
        if (rs1Data !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL basic_write_x5 got=%h expected=%h", rs1Data, 32'hDEADBEEF);
        end
        checks++;
        if (rs2Data !== 32'h12345678) begin
            failures++;
            $display("[TB] FAIL basic_write_x6 got=%h expected=%h", rs2Data, 32'h12345678);
        end
    endtask

    task automatic test_x0_write();
        driveInputs(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        checks++;
        if (rs1Data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL x0_same_cycle got=%h expected=%h", rs1Data, 32'h0);
        end
        stepClock();
        #1;
        checks++;
        if (rs1Data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL x0_next_cycle_rs1 got=%h expected=%h", rs1Data, 32'h0);
        end
        checks++;
        if (rs2Data !== 32'h0) begin
            failures++;
            $display("[TB] FAIL x0_next_cycle_rs2 got=%h expected=%h", rs2Data, 32'h0);
        end
        stepClock();
    endtask

    task automatic test_bypass();
        driveInputs(1'b0, 1'b1, 5'd7, 32'h00000001, 5'd0, 5'd0);
        stepClock();
        driveInputs(1'b0, 1'b0, 5'd7, 32'hFFFF0000, 5'd7, 5'd7);
        #1;
        checks++;
        if (rs1Data !== 32'h1 || rs2Data !== 32'h1) begin
            failures++;
            $display("[TB] FAIL bypass_no_write got=%h/%h expected=%h", rs1Data, rs2Data, 32'h1);
        end
        driveInputs(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
        #1;
        checks++;
        if (rs1Data !== 32'hA5A5A5A5 || rs2Data !== 32'hA5A5A5A5) begin
            failures++;
            $display("[TB] FAIL bypass_same_cycle got=%h/%h expected=%h", rs1Data, rs2Data, 32'hA5A5A5A5);
        end
        stepClock();
        driveInputs(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        #1;
        checks++;
        if (rs1Data !== 32'hA5A5A5A5 || rs2Data !== 32'hA5A5A5A5) begin
            failures++;
            $display("[TB] FAIL bypass_after_edge got=%h/%h expected=%h", rs1Data, rs2Data, 32'hA5A5A5A5);
        end
        // One port forwarding, the other reading storage
        driveInputs(1'b0, 1'b1, 5'd9, 32'h0BADF00D, 5'd9, 5'd7);
        #1;
        checks++;
        if (rs1Data !== 32'h0BADF00D || rs2Data !== 32'hA5A5A5A5) begin
            failures++;
            $display("[TB] FAIL bypass_one_port got=%h/%h expected=%h/%h", rs1Data, rs2Data, 32'h0BADF00D, 32'hA5A5A5A5);
        end
        stepClock();
    endtask

    task automatic test_reset_priority();
        for (int i = 1; i < 32; i++) begin
            driveInputs(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
            stepClock();
        end
        driveInputs(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd31);
        #1;
        checks++;
        if (rs1Data !== 32'h03030303 || rs2Data !== 32'h1F1F1F1F) begin
            failures++;
            $display("[TB] FAIL fill_readback got=%h/%h expected=%h/%h", rs1Data, rs2Data, 32'h03030303, 32'h1F1F1F1F);
        end
        driveInputs(1'b1, 1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd4);
        #1;
        checks++;
        if (rs1Data !== 32'hCAFEF00D || rs2Data !== 32'h04040404) begin
            failures++;
            $display("[TB] FAIL bypass_during_reset got=%h/%h expected=%h/%h", rs1Data, rs2Data, 32'hCAFEF00D, 32'h04040404);
        end
        stepClock();
        driveInputs(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            rs1Addr = 5'(i);
            rs2Addr = 5'(i);
            #1;
            checks++;
            if (rs1Data !== 32'h0 || rs2Data !== 32'h0) begin
                failures++;
                $display("[TB] FAIL reset_priority_sweep addr=%0d got=%h/%h expected=%h", i, rs1Data, rs2Data, 32'h0);
            end
        end
    endtask

    task automatic test_back_to_back();
        driveInputs(1'b0, 1'b1, 5'd10, 32'h11, 5'd0, 5'd0);
        stepClock();
        rdData = 32'h22;
        stepClock();
        rdData = 32'h33;
        stepClock();
        driveInputs(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd10);
        #1;
        checks++;
        if (rs1Data !== 32'h33 || rs2Data !== 32'h33) begin
            failures++;
            $display("[TB] FAIL back_to_back got=%h/%h expected=%h", rs1Data, rs2Data, 32'h33);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp1;
        logic [31:0] exp2;
        for (int n = 0; n < 400; n++) begin
            driveInputs($urandom_range(0, 39) == 0,
                        1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 11)),
                        $urandom,
                        ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 11)),
                        ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 11)));
            #1;
            exp1 = expectRead(rs1Addr);
            exp2 = expectRead(rs2Addr);
            checks++;
            if (rs1Data !== exp1) begin
                failures++;
                $display("[TB] FAIL random_rs1 iter=%0d addr=%0d got=%h expected=%h", n, rs1Addr, rs1Data, exp1);
            end
            checks++;
            if (rs2Data !== exp2) begin
                failures++;
                $display("[TB] FAIL random_rs2 iter=%0d addr=%0d got=%h expected=%h", n, rs2Addr, rs2Data, exp2);
            end
            stepClock();
        end
        driveInputs(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            rs1Addr = 5'(i);
            rs2Addr = 5'(i);
            #1;
            exp1 = expectRead(5'(i));
            checks++;
            if (rs1Data !== exp1 || rs2Data !== exp1) begin
                failures++;
                $display("[TB] FAIL random_final_sweep addr=%0d got=%h/%h expected=%h", i, rs1Data, rs2Data, exp1);
            end
        end
    endtask

    // Main sequence of scenarios
    initial begin
        driveInputs(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        test_reset();
        test_basic_write();
        test_x0_write();
        test_bypass();
        test_reset_priority();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Guard against a run that never completes
    initial begin
        #200000;
        $display("[TB] FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
